// File: rtl/wwd_display_if.sv
// CPU observation bus into the board display block: WWD capture, live register
// view and PC byte in; segment, anode, LED and strobe-count outputs back out.
interface wwd_display_if #(
  parameter int WORD_SIZE = 16
);
  logic                 wwd_strobe;
  logic [WORD_SIZE-1:0] wwd_data;
  logic [WORD_SIZE-1:0] live_data;
  logic                 show_live;
  logic [7:0]           pc_low;
  logic [1:0]           hist_sel;
  logic [6:0]           seg_n;
  logic [3:0]           an_n;
  logic [7:0]           led;
  logic [7:0]           wwd_cnt;

  modport master (
    output wwd_strobe, wwd_data, live_data, show_live, pc_low, hist_sel,
    input  seg_n, an_n, led, wwd_cnt
  );

  modport slave (
    input  wwd_strobe, wwd_data, live_data, show_live, pc_low, hist_sel,
    output seg_n, an_n, led, wwd_cnt
  );
endinterface

// File: rtl/wwd_display.sv
// Holds WWD results and drives a 4-digit multiplexed hex display plus LED bank.
// Define WWD_HISTORY_EN to keep the last four WWD words selectable by hist_sel.
module wwd_display #(
  parameter int REFRESH_DIV = 50000,
  parameter int WORD_SIZE   = 16
) (
  input  logic         clk,
  input  logic         reset_cpu,
  wwd_display_if.slave bus
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [DIV_W-1:0]     divCnt_q, divCnt_d;
  logic [1:0]           digitIdx_q, digitIdx_d;
  logic [7:0]           wwdCnt_q;
  logic [7:0]           led_q;
  logic [6:0]           seg_q, seg_d;
  logic [3:0]           an_q, an_d;
  logic [WORD_SIZE-1:0] heldWord;
  logic                 heldValid;
  logic [15:0]          dispWord;
  logic                 blank;
  logic [3:0]           nibble;

  function automatic logic [6:0] hexToSeg(input logic [3:0] value);
    case (value)
      4'h0: hexToSeg = 7'b1000000;
      4'h1: hexToSeg = 7'b1111001;
      4'h2: hexToSeg = 7'b0100100;
      4'h3: hexToSeg = 7'b0110000;
      4'h4: hexToSeg = 7'b0011001;
      4'h5: hexToSeg = 7'b0010010;
      4'h6: hexToSeg = 7'b0000010;
      4'h7: hexToSeg = 7'b1111000;
      4'h8: hexToSeg = 7'b0000000;
      4'h9: hexToSeg = 7'b0010000;
      4'hA: hexToSeg = 7'b0001000;
      4'hB: hexToSeg = 7'b0000011;
      4'hC: hexToSeg = 7'b1000110;
      4'hD: hexToSeg = 7'b0100001;
      4'hE: hexToSeg = 7'b0000110;
      default: hexToSeg = 7'b0001110;
    endcase
  endfunction

`ifdef WWD_HISTORY_EN
  logic [WORD_SIZE-1:0] hist_q [4];
  logic [1:0]           wrPtr_q;
  logic [2:0]           fill_q;
  logic [1:0]           rdIdx;

  always_ff @(posedge clk or posedge reset_cpu) begin
    if (reset_cpu) begin
      for (int i = 0; i < 4; i++) hist_q[i] <= '0;
      wrPtr_q <= 2'd0;
      fill_q  <= 3'd0;
    end else if (bus.wwd_strobe) begin
      hist_q[wrPtr_q] <= bus.wwd_data;
      wrPtr_q         <= wrPtr_q + 2'd1;
      if (fill_q != 3'd4) fill_q <= fill_q + 3'd1;
    end
  end

  // The newest entry sits just behind the write pointer; hist_sel walks further back.
  always_comb begin
    rdIdx     = wrPtr_q - 2'd1 - bus.hist_sel;
    heldWord  = hist_q[rdIdx];
    heldValid = ({1'b0, bus.hist_sel} < fill_q);
  end
`else
  logic [WORD_SIZE-1:0] heldWord_q;
  logic                 valid_q;
  logic                 unusedHistSel;

  always_ff @(posedge clk or posedge reset_cpu) begin
    if (reset_cpu) begin
      heldWord_q <= '0;
      valid_q    <= 1'b0;
    end else if (bus.wwd_strobe) begin
      heldWord_q <= bus.wwd_data;
      valid_q    <= 1'b1;
    end
  end

  assign heldWord      = heldWord_q;
  assign heldValid     = valid_q;
  assign unusedHistSel = ^bus.hist_sel;
`endif

  always_comb begin
    divCnt_d   = divCnt_q + DIV_W'(1);
    digitIdx_d = digitIdx_q;
    if (divCnt_q == DIV_LAST) begin
      divCnt_d   = '0;
      digitIdx_d = digitIdx_q + 2'd1;
    end
  end

  // Segment and anode values are computed together from the current index so
  // both registers always describe the same digit.
  always_comb begin
    dispWord = 16'h0000;
    blank    = 1'b0;
    if (bus.show_live) begin
      dispWord = bus.live_data[15:0];
    end else begin
      dispWord = heldWord[15:0];
      blank    = !heldValid;
    end
    nibble = dispWord[{digitIdx_q, 2'b00} +: 4];
    seg_d  = blank ? 7'h7F : hexToSeg(nibble);
    an_d   = blank ? 4'hF : ~(4'b0001 << digitIdx_q);
  end

  always_ff @(posedge clk or posedge reset_cpu) begin
    if (reset_cpu) begin
      divCnt_q   <= '0;
      digitIdx_q <= 2'd0;
      wwdCnt_q   <= 8'd0;
      led_q      <= 8'd0;
      seg_q      <= 7'h7F;
      an_q       <= 4'hF;
    end else begin
      divCnt_q   <= divCnt_d;
      digitIdx_q <= digitIdx_d;
      led_q      <= bus.pc_low;
      seg_q      <= seg_d;
      an_q       <= an_d;
      if (bus.wwd_strobe) wwdCnt_q <= wwdCnt_q + 8'd1;
    end
  end

  assign bus.seg_n   = seg_q;
  assign bus.an_n    = an_q;
  assign bus.led     = led_q;
  assign bus.wwd_cnt = wwdCnt_q;

endmodule

// File: tb/tb_wwd_display.sv
// Directed bench for wwd_display with REFRESH_DIV=2; expected digit scans are
// queued when a display word is set up and popped as the DUT scans them out.
module tb_wwd_display;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } scanExp_t;

  logic clk;
  logic reset_cpu;
  int   total = 0;
  int   bad   = 0;
  scanExp_t sbQ[$];

  wwd_display_if #(.WORD_SIZE(16)) bus ();

  wwd_display #(.REFRESH_DIV(2), .WORD_SIZE(16)) dut (
    .clk       (clk),
    .reset_cpu (reset_cpu),
    .bus       (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [6:0] segOf(input logic [3:0] n);
    logic [6:0] table_v [16];
    table_v = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return table_v[n];
  endfunction

  task automatic applyStimulus(input logic strobe, input logic [15:0] data,
                               input logic showLive, input logic [15:0] live,
                               input logic [7:0] pc, input logic [1:0] hs);
    bus.wwd_strobe = strobe;
    bus.wwd_data   = data;
    bus.show_live  = showLive;
    bus.live_data  = live;
    bus.pc_low     = pc;
    bus.hist_sel   = hs;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkBlank(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      checkOutput({tag, "_an"}, {12'h0, bus.an_n}, 16'h000F);
      checkOutput({tag, "_seg"}, {9'h0, bus.seg_n}, 16'h007F);
    end
  endtask

  // Queue the full scan (each digit lit for two cycles), wait for digit 0 to
  // come up fresh, then compare one queued entry per cycle.
  task automatic scanCheck(input string tag, input logic [15:0] word);
    logic [3:0] prevAn;
    logic       found;
    scanExp_t   e;
    for (int d = 0; d < 4; d++) begin
      for (int r = 0; r < 2; r++) begin
        e.an  = ~(4'b0001 << d);
        e.seg = segOf(word[4*d +: 4]);
        sbQ.push_back(e);
      end
    end
    found = 1'b0;
    @(negedge clk);
    prevAn = bus.an_n;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.an_n == 4'b1110 && prevAn != 4'b1110) found = 1'b1;
      else prevAn = bus.an_n;
    end
    if (!found) begin
      checkOutput({tag, "_sync"}, {12'h0, bus.an_n}, 16'h000E);
      sbQ.delete();
      return;
    end
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkOutput({tag, "_an"}, {12'h0, bus.an_n}, {12'h0, e.an});
      checkOutput({tag, "_seg"}, {9'h0, bus.seg_n}, {9'h0, e.seg});
      if (sbQ.size() > 0) @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0]  expCnt;
    logic [15:0] lastData;

    reset_cpu = 1'b1;
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 8'hAA, 2'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("rst_an", {12'h0, bus.an_n}, 16'h000F);
      checkOutput("rst_seg", {9'h0, bus.seg_n}, 16'h007F);
      checkOutput("rst_led", {8'h0, bus.led}, 16'h0000);
      checkOutput("rst_cnt", {8'h0, bus.wwd_cnt}, 16'h0000);
    end
    reset_cpu = 1'b0;
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 8'h00, 2'd0);
    checkBlank("noval", 4);

    $display("[TB] capture 1234");
    applyStimulus(1'b1, 16'h1234, 1'b0, 16'h0, 8'h00, 2'd0);
    @(negedge clk);
    checkOutput("cnt_first", {8'h0, bus.wwd_cnt}, 16'h0001);
    applyStimulus(1'b0, 16'hFFFF, 1'b0, 16'h0, 8'h00, 2'd0);
    expCnt = 8'd1;
    scanCheck("held1234", 16'h1234);

    $display("[TB] live view");
    applyStimulus(1'b0, 16'h0, 1'b1, 16'hABCD, 8'h00, 2'd0);
    scanCheck("liveABCD", 16'hABCD);
    applyStimulus(1'b0, 16'h0, 1'b0, 16'hABCD, 8'h00, 2'd0);
    scanCheck("back1234", 16'h1234);

    $display("[TB] led follow");
    @(negedge clk);
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 8'h15, 2'd0);
    #1;
    checkOutput("led_hold", {8'h0, bus.led}, 16'h0000);
    @(negedge clk);
    checkOutput("led_15", {8'h0, bus.led}, 16'h0015);
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 8'h16, 2'd0);
    #1;
    checkOutput("led_hold15", {8'h0, bus.led}, 16'h0015);
    @(negedge clk);
    checkOutput("led_16", {8'h0, bus.led}, 16'h0016);

    $display("[TB] counter wrap");
    lastData = 16'h0;
    for (int i = 0; i < 255; i++) begin
      lastData = 16'h6000 + 16'(i);
      applyStimulus(1'b1, lastData, 1'b0, 16'h0, 8'h16, 2'd0);
      @(negedge clk);
      expCnt = expCnt + 8'd1;
      if (i == 253) checkOutput("cnt_255", {8'h0, bus.wwd_cnt}, {8'h0, expCnt});
    end
    checkOutput("cnt_wrap", {8'h0, bus.wwd_cnt}, 16'h0000);
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 8'h16, 2'd0);
    scanCheck("heldLast", 16'h60FE);

`ifdef WWD_HISTORY_EN
    $display("[TB] history");
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 16'(i), 1'b0, 16'h0, 8'h16, 2'd0);
      @(negedge clk);
    end
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 8'h16, 2'd3);
    scanCheck("hist3", 16'h0002);
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 8'h16, 2'd0);
    scanCheck("hist0", 16'h0005);
`else
    $display("[TB] hist_sel ignored");
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 8'h16, 2'd3);
    scanCheck("histIgn", 16'h60FE);
`endif

    $display("[TB] reset mid-scan");
    @(negedge clk);
    reset_cpu = 1'b1;
    #1;
    checkOutput("midrst_an", {12'h0, bus.an_n}, 16'h000F);
    checkOutput("midrst_seg", {9'h0, bus.seg_n}, 16'h007F);
    checkOutput("midrst_cnt", {8'h0, bus.wwd_cnt}, 16'h0000);
    checkOutput("midrst_led", {8'h0, bus.led}, 16'h0000);
    @(negedge clk);
    reset_cpu = 1'b0;
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 8'h00, 2'd0);
    checkBlank("postrst", 6);

`ifdef WWD_HISTORY_EN
    applyStimulus(1'b1, 16'h00AB, 1'b0, 16'h0, 8'h00, 2'd0);
    @(negedge clk);
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 8'h00, 2'd1);
    checkBlank("hist1blank", 4);
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 8'h00, 2'd0);
    scanCheck("histAB", 16'h00AB);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wwd_display.md
Name: wwd_display

Overview:
- Consumer of the CPU's observation outputs: the WWD result word, the selected-register view and the PC low byte.
- Captures each WWD result and holds it.
- Drives a 4-digit multiplexed 7-segment display (hex) and an 8-bit LED bank on the FPGA board.
- Sits between the CPU and the board I/O pins; replaces ad-hoc output wiring.

Parameters:
- REFRESH_DIV, 50000, clk cycles each digit stays lit; legal range >=1; bench uses 2.
- WORD_SIZE, 16, width of the displayed data word.

Ports:
- clk  input  1  system clock.
- reset_cpu  input  1  asynchronous, active-high reset.
- wwd_strobe  input  1  single-cycle pulse; the CPU executed a WWD with cpu_enable and wwd_enable high.
- wwd_data  input  WORD_SIZE  WWD result word; valid while wwd_strobe=1.
- live_data  input  WORD_SIZE  register_selection view from the register file.
- show_live  input  1  1 = display live_data; 0 = display the held WWD value.
- pc_low  input  8  lower 8 bits of the current PC.
- hist_sel  input  2  history index; used only with WWD_HISTORY_EN.
- seg_n  output  7  active-low segments; [6]=g ... [0]=a.
- an_n  output  4  active-low digit enables; [0] = rightmost digit (bits 3:0).
- led  output  8  registered copy of pc_low.
- wwd_cnt  output  8  number of WWD strobes seen, modulo 256.

Behaviour:

Reset (async, immediate, including mid-scan):
- seg_n=7'h7F, an_n=4'hF, led=0, wwd_cnt=0.
- Held word = 0, valid flag = 0.
- Divider = 0, digit index = 0.

Capture:
- On a posedge with wwd_strobe=1: held word <= wwd_data, valid <= 1, wwd_cnt <= wwd_cnt+1.
- wwd_cnt wraps 255 -> 0.
- The strobe is accepted in the same cycle as a digit advance, with no loss.

Display word:
- show_live=1: live_data.
- show_live=0: the held word.
- Blanked when show_live=0 and valid=0.
- The display word is sampled combinationally each cycle; no latency beyond the output register.

Refresh:
- Divider counts 0..REFRESH_DIV-1.
- At the terminal count the divider returns to 0 and the digit index advances 0->1->2->3->0.
- REFRESH_DIV=1 advances the digit every cycle.

Outputs:
- seg_n and an_n are registered together every cycle, so there are no glitches between them.
- Digit d shows nibble word[4d+3:4d]; an_n has bit d low and the other bits high.
- When blank: an_n=4'hF and seg_n=7'h7F.
- Output latency: 1 cycle after an index or data change.

Hex decode (seg_n, gfedcba):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000
- 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011
- C=1000110, d=0100001, E=0000110, F=0001110

LED:
- led <= pc_low every cycle; 1-cycle delay.

Optional Feature:

WWD_HISTORY_EN defined:
- 4-entry circular buffer of WWD words.
- The write pointer advances on each strobe.
- A fill count saturates at 4.
- With show_live=0, the display shows the entry hist_sel back from the newest: 0 = newest, 3 = oldest.
- An entry not yet written (hist_sel >= fill count) displays blank.
- Reset clears the pointer, fill count and all entries.

WWD_HISTORY_EN undefined:
- Single held word only.
- hist_sel is ignored; the port remains present.

Test Plan:
1. Assert reset_cpu with show_live=0 and no strobe for 20 cycles -> seg_n=7'h7F, an_n=4'hF, led=0, wwd_cnt=0 throughout.
2. REFRESH_DIV=2; pulse wwd_strobe with wwd_data=16'h1234 -> wwd_cnt=1. Over 8 cycles an_n steps 1110,1101,1011,0111 with seg_n 0011001, 0110000, 0100100, 1111001.
3. Set show_live=1, live_data=16'hABCD -> digits 0..3 show seg_n 0100001 (d), 1000110 (C), 0000011 (b), 0001000 (A). Drop show_live -> the display returns to 1234.
4. pc_low=8'h15 -> led=8'h15 one cycle later. Change to 8'h16 -> led follows next cycle.
5. 256 strobes, one aligned with a digit advance -> wwd_cnt wraps to 0, and the held word equals the last wwd_data.
6. WWD_HISTORY_EN: strobe 0x0001..0x0005, then hist_sel=3 -> the display shows 0002. Then reset mid-scan -> an_n=4'hF immediately; after release, hist_sel=0 is blank.
